// File: rtl/beta_mem_arbiter_if.sv
// Bundle of the Beta core's fetch/data ports and the shared single-port memory bus.
// master = arbiter view, slave = core + memory environment view.
interface beta_mem_arbiter_if #(
  parameter int unsigned AW = 30
);
  logic          i_req;
  logic [31:0]   i_addr;
  logic [31:0]   i_data;
  logic          i_ready;

  logic          d_re;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_ready;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;

  modport master (
    input  i_req, i_addr, d_re, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_data, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_re, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_data, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/beta_mem_arbiter.sv
// Serialises the Beta fetch and data ports onto one req/ack memory bus.
// Data wins arbitration unless FAIR lets a previously beaten fetch go first.
module beta_mem_arbiter #(
  parameter int unsigned AW   = 30,
  parameter bit          FAIR = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  beta_mem_arbiter_if.master bus
);
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    IDROP = 2'd3
  } state_e;

  state_e        state_q;
  logic          req_q;
  logic          we_q;
  logic          fair_q;
  logic          i_ready_q;
  logic          d_ready_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] i_data_q;
  logic [DW-1:0] d_rdata_q;

  logic [AW-1:0] i_word_c;
  logic [AW-1:0] d_word_c;
  logic          arb_en_c;
  logic          d_pend_c;
  logic          grant_d_c;
  logic          grant_i_c;
  logic          i_match_c;
  logic          unused_addr_lsb;

  assign i_word_c        = bus.i_addr[AW+1:2];
  assign d_word_c        = bus.d_addr[AW+1:2];
  assign unused_addr_lsb = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

  // No arbitration during a ready pulse: the core updates its request that cycle.
  assign arb_en_c  = (state_q == IDLE) && !i_ready_q && !d_ready_q;
  assign d_pend_c  = bus.d_re | bus.d_we;
  assign grant_d_c = arb_en_c && d_pend_c && !(FAIR && fair_q && bus.i_req);
  assign grant_i_c = arb_en_c && !grant_d_c && bus.i_req;
  assign i_match_c = bus.i_req && (i_word_c == addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      fair_q    <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_d_c) begin
            addr_q  <= d_word_c;
            wdata_q <= bus.d_wdata;
            we_q    <= bus.d_we;
            state_q <= DBUSY;
            if (bus.i_req) begin
              fair_q <= 1'b1;
            end
          end else if (grant_i_c) begin
            addr_q  <= i_word_c;
            we_q    <= 1'b0;
            fair_q  <= 1'b0;
            state_q <= IBUSY;
          end
        end
        DBUSY: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (bus.mem_ack) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            d_ready_q <= 1'b1;
            state_q   <= IDLE;
            if (!we_q) begin
              d_rdata_q <= bus.mem_rdata;
            end
          end
        end
        IBUSY: begin
          if (req_q && bus.mem_ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
            if (i_match_c) begin
              i_data_q  <= bus.mem_rdata;
              i_ready_q <= 1'b1;
            end
          end else begin
            req_q <= 1'b1;
            // PC moved while in flight: finish the access but throw it away.
            if (i_word_c != addr_q) begin
              state_q <= IDROP;
            end
          end
        end
        IDROP: begin
          if (req_q && bus.mem_ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            req_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_data    = i_data_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;
endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Directed and randomized bench for beta_mem_arbiter with a word-level memory model.
// A second instance with FAIR=0 covers strict data priority.
module tb_beta_mem_arbiter;
  localparam int unsigned AW = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;

  beta_mem_arbiter_if #(.AW(AW)) b ();
  beta_mem_arbiter_if #(.AW(AW)) nb ();

  beta_mem_arbiter #(.AW(AW), .FAIR(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  beta_mem_arbiter #(.AW(AW), .FAIR(1'b0)) u_nofair (
    .clk (clk),
    .rst (rst),
    .bus (nb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Initial memory contents, shared definition of what an unwritten word holds.
  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    if (a == AW'(32'h40)) return 32'hC01F_0004;
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A_96E1;
  endfunction

  // Memory-side storage (bus view) and core-side expectation (model view).
  logic [31:0] mem_store [bit [AW-1:0]];
  logic [31:0] ref_mem   [bit [AW-1:0]];

  function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  assign nb.mem_ack   = nb.mem_req;
  assign nb.mem_rdata = init_word(nb.mem_addr);

  // Memory responder for the main instance.
  bit            resp_en   = 1'b1;
  bit            rand_wait = 1'b0;
  int            ack_wait  = 0;
  bit            in_txn    = 1'b0;
  int            wcnt      = 0;
  int            stab_err  = 0;
  logic [AW-1:0] t_addr;
  logic          t_we;
  logic [31:0]   t_wdata;
  logic [AW-1:0] txn_q[$];

  task automatic raise_ack();
    b.mem_ack = 1'b1;
    if (t_we) begin
      mem_store[t_addr] = t_wdata;
      b.mem_rdata = $urandom;
    end else begin
      b.mem_rdata = mem_rd(t_addr);
    end
  endtask

  initial begin
    b.mem_ack   = 1'b0;
    b.mem_rdata = '0;
    forever begin
      step();
      if (resp_en) begin
        if (b.mem_ack) begin
          b.mem_ack = 1'b0;
          in_txn    = 1'b0;
        end else if (in_txn && !b.mem_req) begin
          in_txn = 1'b0;
        end else if (in_txn) begin
          if (b.mem_addr !== t_addr || b.mem_we !== t_we || b.mem_wdata !== t_wdata) stab_err++;
          wcnt--;
          if (wcnt <= 0) raise_ack();
        end
        if (!in_txn && b.mem_req && !b.mem_ack) begin
          in_txn  = 1'b1;
          t_addr  = b.mem_addr;
          t_we    = b.mem_we;
          t_wdata = b.mem_wdata;
          txn_q.push_back(t_addr);
          wcnt = rand_wait ? int'($urandom_range(0, 7)) : ack_wait;
          if (wcnt <= 0) raise_ack();
        end
      end
    end
  end

  int i_pulses = 0;
  int d_pulses = 0;
  int both_hi  = 0;
  always @(negedge clk) begin
    if (b.i_ready) i_pulses++;
    if (b.d_ready) d_pulses++;
    if (b.i_ready && b.d_ready) both_hi++;
  end

  task automatic wait_ready(input int limit, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(b.i_ready || b.d_ready) && cyc < limit);
  endtask

  task automatic wait_nb(input int limit);
    int cyc;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(nb.i_ready || nb.d_ready) && cyc < limit);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int            cyc, ip0, dp0, n0, reqc, bad;
    logic [31:0]   exp_drd;
    bit            i_pend, d_pend, d_wr;
    int            i_age, d_age, n_i, n_d;
    logic [AW-1:0] i_word, d_word;
    logic [31:0]   d_wd, a32;
    int            op;

    b.i_req = 1'b0;  b.i_addr = '0;  b.d_re = 1'b0;  b.d_we = 1'b0;
    b.d_addr = '0;   b.d_wdata = '0;
    nb.i_req = 1'b0; nb.i_addr = '0; nb.d_re = 1'b0; nb.d_we = 1'b0;
    nb.d_addr = '0;  nb.d_wdata = '0;
    exp_drd = '0;

    // Reset values
    #2 rst = 1'b1;
    step(); step();
    chk("rst_mem_req",   64'(b.mem_req),   64'd0);
    chk("rst_mem_we",    64'(b.mem_we),    64'd0);
    chk("rst_mem_addr",  64'(b.mem_addr),  64'd0);
    chk("rst_mem_wdata", 64'(b.mem_wdata), 64'd0);
    chk("rst_i_ready",   64'(b.i_ready),   64'd0);
    chk("rst_d_ready",   64'(b.d_ready),   64'd0);
    chk("rst_i_data",    64'(b.i_data),    64'd0);
    chk("rst_d_rdata",   64'(b.d_rdata),   64'd0);
    rst = 1'b0;
    step();

    // Fetch only, zero-wait memory
    ack_wait = 0;
    ip0 = i_pulses;
    b.i_req = 1'b1; b.i_addr = 32'h100;
    cyc = 0;
    while (!b.i_ready && cyc < 10) begin
      step();
      cyc++;
      if (cyc == 2) begin
        chk("fetch_mem_req",  64'(b.mem_req),  64'd1);
        chk("fetch_mem_addr", 64'(b.mem_addr), 64'h40);
      end
    end
    chk("fetch_latency", 64'(cyc), 64'd3);
    chk("fetch_i_data", 64'(b.i_data), 64'hC01F_0004);
    b.i_req = 1'b0;
    step(); step(); step();
    chk("fetch_one_pulse", 64'(i_pulses - ip0), 64'd1);

    // Simultaneous requests, FAIR=1
    b.i_req = 1'b1; b.i_addr = 32'h0;
    b.d_re = 1'b1;  b.d_addr = 32'h200;
    wait_ready(15, cyc);
    chk("sim_first_d", 64'(b.d_ready), 64'd1);
    chk("sim_first_not_i", 64'(b.i_ready), 64'd0);
    chk("sim_d_mem_addr", 64'(txn_q[$]), 64'h80);
    exp_drd = ref_rd(AW'(32'h80));
    chk("sim_d_rdata", 64'(b.d_rdata), 64'(exp_drd));
    b.d_re = 1'b0; b.d_we = 1'b1; b.d_addr = 32'h300; b.d_wdata = 32'h1234_5678;
    wait_ready(15, cyc);
    chk("fair_fetch_next", 64'(b.i_ready), 64'd1);
    chk("fair_fetch_data", 64'(b.i_data), 64'(init_word(AW'(0))));
    b.i_req = 1'b0;
    wait_ready(15, cyc);
    chk("fair_write_last", 64'(b.d_ready), 64'd1);
    chk("fair_write_hold_rdata", 64'(b.d_rdata), 64'(exp_drd));
    ref_mem[AW'(32'hC0)] = 32'h1234_5678;
    chk("fair_write_landed", 64'(mem_rd(AW'(32'hC0))), 64'(ref_rd(AW'(32'hC0))));
    b.d_we = 1'b0;
    step();

    // Same scenario with FAIR=0: pending write beats the fetch
    nb.i_req = 1'b1; nb.i_addr = 32'h0;
    nb.d_re = 1'b1;  nb.d_addr = 32'h200;
    wait_nb(15);
    chk("nofair_first_d", 64'(nb.d_ready), 64'd1);
    chk("nofair_d_rdata", 64'(nb.d_rdata), 64'(init_word(AW'(32'h80))));
    nb.d_re = 1'b0; nb.d_we = 1'b1; nb.d_addr = 32'h300; nb.d_wdata = 32'hA5A5_0000;
    wait_nb(15);
    chk("nofair_write_second", 64'(nb.d_ready), 64'd1);
    chk("nofair_write_hold", 64'(nb.d_rdata), 64'(init_word(AW'(32'h80))));
    nb.d_we = 1'b0;
    wait_nb(15);
    chk("nofair_fetch_third", 64'(nb.i_ready), 64'd1);
    chk("nofair_fetch_data", 64'(nb.i_data), 64'(init_word(AW'(0))));
    nb.i_req = 1'b0;
    step();

    // Store with 4 wait cycles
    ack_wait = 4;
    dp0 = d_pulses;
    b.d_we = 1'b1; b.d_re = 1'b0; b.d_addr = 32'h3FC; b.d_wdata = 32'hDEAD_BEEF;
    reqc = 0; bad = 0; cyc = 0;
    while (!b.d_ready && cyc < 30) begin
      step();
      cyc++;
      if (b.mem_req) begin
        reqc++;
        if (b.mem_we !== 1'b1 || b.mem_addr !== AW'(32'hFF) || b.mem_wdata !== 32'hDEAD_BEEF) bad++;
      end
    end
    chk("store_req_cycles", 64'(reqc), 64'd5);
    chk("store_bus_stable", 64'(bad), 64'd0);
    chk("store_d_ready", 64'(b.d_ready), 64'd1);
    chk("store_rdata_hold", 64'(b.d_rdata), 64'(exp_drd));
    b.d_we = 1'b0;
    ref_mem[AW'(32'hFF)] = 32'hDEAD_BEEF;
    step(); step(); step();
    chk("store_one_pulse", 64'(d_pulses - dp0), 64'd1);
    chk("store_landed", 64'(mem_rd(AW'(32'hFF))), 64'(ref_rd(AW'(32'hFF))));

    // Redirect mid-fetch
    ack_wait = 5;
    n0 = txn_q.size();
    ip0 = i_pulses;
    b.i_req = 1'b1; b.i_addr = 32'h10;
    cyc = 0;
    while (!b.mem_req && cyc < 10) begin
      step();
      cyc++;
    end
    step();
    b.i_addr = 32'h80;
    wait_ready(40, cyc);
    chk("redir_i_ready", 64'(b.i_ready), 64'd1);
    chk("redir_i_data", 64'(b.i_data), 64'(init_word(AW'(32'h20))));
    chk("redir_txn_count", 64'(txn_q.size() - n0), 64'd2);
    chk("redir_txn_new_addr", 64'(txn_q[$]), 64'h20);
    b.i_req = 1'b0;
    step(); step(); step();
    chk("redir_one_pulse", 64'(i_pulses - ip0), 64'd1);

    // Reset with mem_req high, then a stale ack
    ack_wait = 7;
    b.i_req = 1'b1; b.i_addr = 32'h40;
    cyc = 0;
    while (!b.mem_req && cyc < 10) begin
      step();
      cyc++;
    end
    chk("rstmid_req_up", 64'(b.mem_req), 64'd1);
    ip0 = i_pulses; dp0 = d_pulses;
    #2;
    resp_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_req_async_drop", 64'(b.mem_req), 64'd0);
    b.i_req = 1'b0;
    step(); step();
    rst = 1'b0;
    exp_drd = '0;
    step();
    b.mem_ack = 1'b1;
    step();
    b.mem_ack = 1'b0;
    step(); step();
    chk("rstmid_no_i_pulse", 64'(i_pulses - ip0), 64'd0);
    chk("rstmid_no_d_pulse", 64'(d_pulses - dp0), 64'd0);
    chk("rstmid_req_low", 64'(b.mem_req), 64'd0);
    chk("rstmid_addr_clear", 64'(b.mem_addr), 64'd0);
    chk("rstmid_i_data_clear", 64'(b.i_data), 64'd0);
    resp_en = 1'b1;
    ack_wait = 0;
    b.i_req = 1'b1; b.i_addr = 32'h40;
    wait_ready(15, cyc);
    chk("rstmid_resume_ready", 64'(b.i_ready), 64'd1);
    chk("rstmid_resume_data", 64'(b.i_data), 64'(init_word(AW'(32'h10))));
    b.i_req = 1'b0;
    step();

    // Random traffic with 0-7 wait states
    rand_wait = 1'b1;
    n0 = txn_q.size();
    n_i = 0; n_d = 0; i_pend = 1'b0; d_pend = 1'b0; i_age = 0; d_age = 0;
    d_wr = 1'b0; i_word = '0; d_word = '0; d_wd = '0;
    for (int c = 0; c < 2000; c++) begin
      step();
      if (b.i_ready) begin
        chk("sweep_i_pending", 64'(i_pend), 64'd1);
        chk("sweep_i_data", 64'(b.i_data), 64'(init_word(i_word)));
        chk("sweep_i_age_bound", 64'(i_age <= 80), 64'd1);
        b.i_req = 1'b0; i_pend = 1'b0; n_i++;
      end
      if (b.d_ready) begin
        chk("sweep_d_pending", 64'(d_pend), 64'd1);
        chk("sweep_d_age_bound", 64'(d_age <= 80), 64'd1);
        if (d_wr) begin
          ref_mem[d_word] = d_wd;
          chk("sweep_d_rdata_hold", 64'(b.d_rdata), 64'(exp_drd));
        end else begin
          exp_drd = ref_rd(d_word);
          chk("sweep_d_rdata", 64'(b.d_rdata), 64'(exp_drd));
        end
        b.d_re = 1'b0; b.d_we = 1'b0; d_pend = 1'b0; n_d++;
      end
      if (i_pend) i_age++;
      if (d_pend) d_age++;
      if (!i_pend && c < 1700 && $urandom_range(0, 2) == 0) begin
        a32 = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        i_word = AW'(a32 >> 2);
        b.i_addr = a32; b.i_req = 1'b1; i_pend = 1'b1; i_age = 0;
      end
      if (!d_pend && c < 1700 && $urandom_range(0, 2) == 0) begin
        a32 = {20'h1, 4'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        d_word = AW'(a32 >> 2);
        op = int'($urandom_range(0, 2));
        d_wr = (op != 0);
        d_wd = $urandom;
        b.d_addr = a32; b.d_wdata = d_wd;
        b.d_re = (op != 1); b.d_we = d_wr;
        d_pend = 1'b1; d_age = 0;
      end
    end
    chk("sweep_i_drained", 64'(i_pend), 64'd0);
    chk("sweep_d_drained", 64'(d_pend), 64'd0);
    chk("sweep_no_dup_or_loss", 64'(txn_q.size() - n0), 64'(n_i + n_d));
    chk("sweep_activity", 64'(n_i > 20 && n_d > 20), 64'd1);
    chk("bus_stable_while_req", 64'(stab_err), 64'd0);
    chk("ready_never_both", 64'(both_hi), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
